// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC owner, instruction-memory handshake and IF/ID register.
// Optional PERF_CNT_EN adds saturating stall/flush counters. Rev 1.0
`default_nettype none

module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        CLR,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        ID_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_valid
`ifdef PERF_CNT_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] KILL  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] target;

  assign pc_plus4 = pc_q + 32'd4;
  assign target   = branch_target & ~32'h0000_0003;

  // KILL keeps the outstanding address on the bus while PC already holds the target
  assign imem_req  = (state_q == FETCH) || (state_q == KILL);
  assign imem_addr = (state_q == KILL) ? kill_addr_q : pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (branch_taken) begin
          instr_d     = 32'd0;
          valid_d     = 1'b0;
          pc_d        = target;
          kill_addr_d = pc_q;
          state_d     = imem_ready ? FETCH : KILL;
        end else if (imem_ready) begin
          pc_d = pc_plus4;
          if (ID_stall) begin
            buf_instr_d = imem_data;
            buf_pc4_d   = pc_plus4;
            state_d     = HOLD;
          end else begin
            instr_d = imem_data;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end else if (!ID_stall) begin
          instr_d = 32'd0;
          valid_d = 1'b0;
        end
      end
      KILL: begin
        instr_d = 32'd0;
        valid_d = 1'b0;
        if (branch_taken) pc_d = target;
        if (imem_ready) state_d = FETCH;
      end
      HOLD: begin
        if (branch_taken) begin
          buf_instr_d = 32'd0;
          buf_pc4_d   = 32'd0;
          instr_d     = 32'd0;
          valid_d     = 1'b0;
          pc_d        = target;
          state_d     = FETCH;
        end else if (!ID_stall) begin
          instr_d = buf_instr_q;
          pc4_d   = buf_pc4_q;
          valid_d = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
      instr_q     <= 32'd0;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  assign IF_ID_instr = instr_q;
  assign IF_ID_PC4   = pc4_q;
  assign IF_ID_valid = valid_q;

`ifdef PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ID_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (branch_taken && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: directed checks of instr_fetch_stage. Rev 1.0
`default_nettype none

module tb_instr_fetch_stage;

  logic        clk;
  logic        clr;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic        imem_ready;
  logic [31:0] imem_data, imem_data2;
  logic        id_stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] if_instr, if_instr2;
  logic [31:0] if_pc4, if_pc42;
  logic        if_valid, if_valid2;

  int n_tests = 0;
  int n_fail  = 0;

  // memory returns its own address as the instruction word
  assign imem_data  = imem_addr;
  assign imem_data2 = imem_addr2;

  instr_fetch_stage u_dut (
    .CLK(clk), .CLR(clr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .ID_stall(id_stall), .branch_taken(br_taken), .branch_target(br_target),
    .IF_ID_instr(if_instr), .IF_ID_PC4(if_pc4), .IF_ID_valid(if_valid)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .CLK(clk), .CLR(clr),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(1'b1), .imem_data(imem_data2),
    .ID_stall(1'b0), .branch_taken(1'b0), .branch_target(32'd0),
    .IF_ID_instr(if_instr2), .IF_ID_PC4(if_pc42), .IF_ID_valid(if_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                        input logic valid);
    check_eq({tag, "_instr"}, if_instr, instr);
    check_eq({tag, "_pc4"}, if_pc4, pc4);
    check_eq({tag, "_valid"}, {31'd0, if_valid}, {31'd0, valid});
  endtask

  initial begin
    clr = 1'b1; imem_ready = 1'b0; id_stall = 1'b0; br_taken = 1'b0; br_target = 32'd0;
    step(); step();
    // reset state
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'd0);
    chk_if("rst", 32'd0, 32'd0, 1'b0);
    check_eq("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);
    clr = 1'b0; imem_ready = 1'b1;

    step();
    check_eq("first_req", {31'd0, imem_req}, 32'd1);
    check_eq("first_addr", imem_addr, 32'd0);
    check_eq("first_valid", {31'd0, if_valid}, 32'd0);
    check_eq("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);

    // streaming
    step(); chk_if("s0", 32'h0, 32'h4, 1'b1);
    check_eq("wrap_instr", if_instr2, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", if_pc42, 32'h0);
    check_eq("wrap_next_addr", imem_addr2, 32'h0);
    step(); chk_if("s1", 32'h4, 32'h8, 1'b1);
    step(); chk_if("s2", 32'h8, 32'hC, 1'b1);
    step(); chk_if("s3", 32'hC, 32'h10, 1'b1);
    check_eq("s3_addr", imem_addr, 32'h10);

    // stall while word 0x10 returns
    id_stall = 1'b1;
    step();
    check_eq("hold1_req", {31'd0, imem_req}, 32'd0);
    chk_if("hold1", 32'hC, 32'h10, 1'b1);
    step();
    check_eq("hold2_req", {31'd0, imem_req}, 32'd0);
    chk_if("hold2", 32'hC, 32'h10, 1'b1);
    id_stall = 1'b0;
    step();
    chk_if("release", 32'h10, 32'h14, 1'b1);
    check_eq("release_addr", imem_addr, 32'h14);
    check_eq("release_req", {31'd0, imem_req}, 32'd1);

    // three wait states on 0x14
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("wait_instr", if_instr, 32'd0);
      check_eq("wait_valid", {31'd0, if_valid}, 32'd0);
      check_eq("wait_addr", imem_addr, 32'h14);
    end
    imem_ready = 1'b1;
    step(); chk_if("wait_done", 32'h14, 32'h18, 1'b1);
    step(); step();
    check_eq("pre_br_addr", imem_addr, 32'h20);

    // branch while 0x20 is pending, ready two cycles later
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h103;
    step();
    br_taken = 1'b0;
    check_eq("kill1_addr", imem_addr, 32'h20);
    check_eq("kill1_req", {31'd0, imem_req}, 32'd1);
    check_eq("kill1_valid", {31'd0, if_valid}, 32'd0);
    step();
    check_eq("kill2_addr", imem_addr, 32'h20);
    imem_ready = 1'b1;
    step();
    check_eq("kill_drop_valid", {31'd0, if_valid}, 32'd0);
    check_eq("kill_drop_instr", if_instr, 32'd0);
    check_eq("redirect_addr", imem_addr, 32'h100);
    step(); chk_if("tgt", 32'h100, 32'h104, 1'b1);

    // CLR while in KILL
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h200;
    step();
    br_taken = 1'b0;
    check_eq("kill3_addr", imem_addr, 32'h104);
    clr = 1'b1; imem_ready = 1'b1;
    step();
    check_eq("clr_req", {31'd0, imem_req}, 32'd0);
    check_eq("clr_addr", imem_addr, 32'd0);
    chk_if("clr", 32'd0, 32'd0, 1'b0);
    clr = 1'b0;
    step();
    check_eq("clr_fetch_addr", imem_addr, 32'd0);
    step(); chk_if("clr_s0", 32'h0, 32'h4, 1'b1);

    // branch coinciding with ready: word discarded, no KILL
    br_taken = 1'b1; br_target = 32'h40;
    step();
    br_taken = 1'b0;
    check_eq("brr_valid", {31'd0, if_valid}, 32'd0);
    check_eq("brr_addr", imem_addr, 32'h40);
    step(); chk_if("brr_tgt", 32'h40, 32'h44, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
